// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and keep/byte helpers for the AXI-Stream header insert/remove blocks.
// Keep vectors are handled right-aligned in a MAX_BYTES field, with byte 0 at bit nbytes-1.
package axi_stream_hdr_pkg;

  localparam int unsigned MAX_BYTES  = 64;
  localparam int unsigned BYTE_WD    = 8;
  localparam int unsigned BYTE_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } hdr_state_e;

  // Leading-ones count of the nbytes-wide keep field.
  function automatic int unsigned keep_to_cnt(input logic [MAX_BYTES-1:0] keep,
                                              input int unsigned          nbytes);
    logic [MAX_BYTES-1:0] k;
    logic                 run;
    int unsigned          cnt;
    k   = keep << (MAX_BYTES - nbytes);
    run = 1'b1;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (run && (i < nbytes) && k[MAX_BYTES-1]) begin
        cnt++;
      end else begin
        run = 1'b0;
      end
      k = k << 1;
    end
    return cnt;
  endfunction

  // cnt leading ones inside an nbytes-wide keep field.
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int unsigned cnt,
                                                       input int unsigned nbytes);
    return ~({MAX_BYTES{1'b1}} >> cnt) >> (MAX_BYTES - nbytes);
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational byte merge: residual bytes followed by the head of the new beat,
// plus the post-header tail of the beat that becomes the next residual.
module axis_byte_realign
  import axi_stream_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      resid_data,
  input  logic [BYTE_CNT_WD-1:0]  resid_cnt,
  input  logic [DATA_WD-1:0]      beat_data,
  input  logic [BYTE_CNT_WD-1:0]  beat_cnt,
  input  logic [BYTE_CNT_WD-1:0]  hdr_cnt,
  output logic [DATA_WD-1:0]      merge_data_c,
  output logic [DATA_BYTE_WD-1:0] merge_keep_c,
  output logic [DATA_WD-1:0]      tail_data_c,
  output logic [DATA_BYTE_WD-1:0] tail_keep_c,
  output logic [BYTE_CNT_WD-1:0]  tail_cnt_c,
  output logic [DATA_WD-1:0]      hdr_data_c
);

  logic [BYTE_CNT_WD-1:0] take_cnt;
  logic [BYTE_CNT_WD-1:0] fill_cnt;

  function automatic logic [DATA_WD-1:0] lead_mask(input logic [BYTE_CNT_WD-1:0] cnt);
    return ~({DATA_WD{1'b1}} >> {cnt, BYTE_SHIFT'(0)});
  endfunction

  always_comb begin
    take_cnt     = (beat_cnt < hdr_cnt) ? beat_cnt : hdr_cnt;
    fill_cnt     = resid_cnt + take_cnt;
    merge_data_c = resid_data | ((beat_data & lead_mask(take_cnt)) >> {resid_cnt, BYTE_SHIFT'(0)});
    merge_keep_c = DATA_BYTE_WD'(cnt_to_keep(32'(fill_cnt), DATA_BYTE_WD));
    tail_cnt_c   = (beat_cnt > hdr_cnt) ? (beat_cnt - hdr_cnt) : '0;
    tail_data_c  = (beat_data & lead_mask(beat_cnt)) << {hdr_cnt, BYTE_SHIFT'(0)};
    tail_keep_c  = DATA_BYTE_WD'(cnt_to_keep(32'(tail_cnt_c), DATA_BYTE_WD));
    hdr_data_c   = beat_data & lead_mask(hdr_cnt);
  end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips a per-packet header of n bytes from an AXI-Stream, realigns the payload to
// byte 0 and reports the removed bytes on the hdr_* sideband.
module axi_stream_remove_header
  import axi_stream_hdr_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,
  output logic                    hdr_valid,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep
);

  localparam logic [BYTE_CNT_WD-1:0] FULL_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);

  hdr_state_e              state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  n_q, n_d;
  logic [DATA_WD-1:0]      resid_data_q, resid_data_d;
  logic [BYTE_CNT_WD-1:0]  resid_cnt_q, resid_cnt_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
  logic                    ready_remove_q, ready_remove_d;

  logic                    out_free_c, accept_c, passthru_c;
  logic                    emit_c, emit_last_c;
  logic [DATA_WD-1:0]      emit_data_c;
  logic [DATA_BYTE_WD-1:0] emit_keep_c;
  logic [BYTE_CNT_WD-1:0]  beat_cnt_c;
  logic [DATA_WD-1:0]      merge_data_c, tail_data_c, hdr_data_c;
  logic [DATA_BYTE_WD-1:0] merge_keep_c, tail_keep_c;
  logic [BYTE_CNT_WD-1:0]  tail_cnt_c;

  assign out_free_c = !valid_out_q || ready_out;
  assign ready_in   = ((state_q == HEAD) || (state_q == BODY)) && out_free_c;
  assign accept_c   = valid_in && ready_in;
  assign passthru_c = (n_q == '0);
  assign beat_cnt_c = BYTE_CNT_WD'(keep_to_cnt(MAX_BYTES'(keep_in), DATA_BYTE_WD));

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .resid_data   (resid_data_q),
    .resid_cnt    (resid_cnt_q),
    .beat_data    (data_in),
    .beat_cnt     (beat_cnt_c),
    .hdr_cnt      (n_q),
    .merge_data_c (merge_data_c),
    .merge_keep_c (merge_keep_c),
    .tail_data_c  (tail_data_c),
    .tail_keep_c  (tail_keep_c),
    .tail_cnt_c   (tail_cnt_c),
    .hdr_data_c   (hdr_data_c)
  );

  // Next-state, residual and output-register update.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    resid_data_d = resid_data_q;
    resid_cnt_d  = resid_cnt_q;
    hdr_valid_d  = 1'b0;
    hdr_data_d   = hdr_data_q;
    hdr_keep_d   = hdr_keep_q;
    emit_c       = 1'b0;
    emit_data_c  = '0;
    emit_keep_c  = '0;
    emit_last_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_remove && ready_remove_q) begin
          n_d     = (byte_remove_cnt > FULL_CNT) ? FULL_CNT : byte_remove_cnt;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (accept_c) begin
          hdr_valid_d  = 1'b1;
          hdr_data_d   = hdr_data_c;
          hdr_keep_d   = DATA_BYTE_WD'(cnt_to_keep(32'(n_q), DATA_BYTE_WD));
          resid_data_d = tail_data_c;
          resid_cnt_d  = tail_cnt_c;
          // With no header the beat passes straight through, keeping one-cycle latency.
          if (passthru_c || (last_in && (tail_cnt_c != '0))) begin
            emit_c      = 1'b1;
            emit_data_c = tail_data_c;
            emit_keep_c = tail_keep_c;
            emit_last_c = last_in;
          end
          state_d = last_in ? IDLE : BODY;
        end
      end
      BODY: begin
        if (accept_c) begin
          emit_c = 1'b1;
          if (passthru_c) begin
            emit_data_c = tail_data_c;
            emit_keep_c = tail_keep_c;
            emit_last_c = last_in;
            state_d     = last_in ? IDLE : BODY;
          end else begin
            emit_data_c  = merge_data_c;
            emit_keep_c  = merge_keep_c;
            emit_last_c  = last_in && (tail_cnt_c == '0);
            resid_data_d = tail_data_c;
            resid_cnt_d  = tail_cnt_c;
            if (last_in) begin
              state_d = (tail_cnt_c == '0) ? IDLE : FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free_c) begin
          emit_c      = 1'b1;
          emit_data_c = resid_data_q;
          emit_keep_c = DATA_BYTE_WD'(cnt_to_keep(32'(resid_cnt_q), DATA_BYTE_WD));
          emit_last_c = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_out_d    = emit_c ? 1'b1 : (valid_out_q && !ready_out);
    data_out_d     = emit_c ? emit_data_c : data_out_q;
    keep_out_d     = emit_c ? emit_keep_c : keep_out_q;
    last_out_d     = emit_c ? emit_last_c : last_out_q;
    ready_remove_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      n_q            <= '0;
      resid_data_q   <= '0;
      resid_cnt_q    <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      hdr_valid_q    <= 1'b0;
      hdr_data_q     <= '0;
      hdr_keep_q     <= '0;
      ready_remove_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      resid_data_q   <= resid_data_d;
      resid_cnt_q    <= resid_cnt_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      keep_out_q     <= keep_out_d;
      last_out_q     <= last_out_d;
      hdr_valid_q    <= hdr_valid_d;
      hdr_data_q     <= hdr_data_d;
      hdr_keep_q     <= hdr_keep_d;
      ready_remove_q <= ready_remove_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign keep_out     = keep_out_q;
  assign last_out     = last_out_q;
  assign hdr_valid    = hdr_valid_q;
  assign hdr_data     = hdr_data_q;
  assign hdr_keep     = hdr_keep_q;
  assign ready_remove = ready_remove_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header: hand-computed beats, headers and
// handshake timing, including back-pressure, clamping and mid-packet reset.
module tb_axi_stream_remove_header;

  localparam int unsigned DATA_WD      = 32;
  localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1;
  localparam int unsigned TIMEOUT      = 50;

  typedef struct packed {
    logic [DATA_WD-1:0]      data;
    logic [DATA_BYTE_WD-1:0] keep;
    logic                    last;
  } beat_t;

  typedef struct packed {
    logic [DATA_WD-1:0]      data;
    logic [DATA_BYTE_WD-1:0] keep;
  } hdr_t;

  logic                    clk;
  logic                    rst_n;
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;
  logic                    valid_remove;
  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt;
  logic                    ready_remove;
  logic                    hdr_valid;
  logic [DATA_WD-1:0]      hdr_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep;

  int    checks   = 0;
  int    failures = 0;
  beat_t out_q[$];
  hdr_t  hdr_q[$];

  axi_stream_remove_header #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_remove    (valid_remove),
    .byte_remove_cnt (byte_remove_cnt),
    .ready_remove    (ready_remove),
    .hdr_valid       (hdr_valid),
    .hdr_data        (hdr_data),
    .hdr_keep        (hdr_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output handshake and every header pulse.
  always @(posedge clk) begin
    if (rst_n && valid_out && ready_out) out_q.push_back('{data_out, keep_out, last_out});
    if (rst_n && hdr_valid) hdr_q.push_back('{hdr_data, hdr_keep});
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx, input logic [DATA_WD-1:0] d,
                           input logic [DATA_BYTE_WD-1:0] k, input logic l);
    beat_t b;
    beat_t e;
    b = 'x;
    if (idx < out_q.size()) b = out_q[idx];
    e = '{d, k, l};
    check(tag, 64'(b), 64'(e));
  endtask

  task automatic check_hdr(input string tag, input logic [DATA_WD-1:0] d,
                           input logic [DATA_BYTE_WD-1:0] k);
    hdr_t h;
    hdr_t e;
    h = 'x;
    if (hdr_q.size() > 0) h = hdr_q[0];
    e = '{d, k};
    check(tag, 64'(h), 64'(e));
  endtask

  task automatic send_cmd(input logic [BYTE_CNT_WD-1:0] n);
    int unsigned waited;
    waited          = 0;
    valid_remove    = 1'b1;
    byte_remove_cnt = n;
    @(negedge clk);
    while (ready_remove !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept", 64'(ready_remove), 64'(1));
    @(posedge clk);
    #1;
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_WD-1:0] d, input logic [DATA_BYTE_WD-1:0] k,
                           input logic l);
    int unsigned waited;
    waited   = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    @(negedge clk);
    while (ready_in !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check("beat_accept", 64'(ready_in), 64'(1));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_q.delete();
    hdr_q.delete();
  endtask

  initial begin
    rst_n           = 1'b0;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    ready_out       = 1'b1;
    valid_remove    = 1'b0;
    byte_remove_cnt = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_keep_out", 64'(keep_out), 64'(0));
    check("rst_last_out", 64'(last_out), 64'(0));
    check("rst_ready_in", 64'(ready_in), 64'(0));
    check("rst_ready_remove", 64'(ready_remove), 64'(0));
    check("rst_hdr_valid", 64'(hdr_valid), 64'(0));
    check("rst_hdr_data", 64'(hdr_data), 64'(0));
    check("rst_hdr_keep", 64'(hdr_keep), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("idle_ready_remove", 64'(ready_remove), 64'(1));
    check("idle_ready_in", 64'(ready_in), 64'(0));

    // n=3, three beats, short last beat
    clear_logs();
    send_cmd(3'd3);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    send_beat(32'h090A0B0C, 4'b1100, 1'b1);
    idle(4);
    check("s1_hdr_count", 64'(hdr_q.size()), 64'(1));
    check_hdr("s1_hdr", 32'h01020300, 4'b1110);
    check("s1_out_count", 64'(out_q.size()), 64'(2));
    check_out("s1_out0", 0, 32'h04050607, 4'b1111, 1'b0);
    check_out("s1_out1", 1, 32'h08090A00, 4'b1110, 1'b1);

    // n=1, full last beat forces a flush beat
    clear_logs();
    send_cmd(3'd1);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);
    check("s2_flush_ready_in", 64'(ready_in), 64'(0));
    idle(4);
    check_hdr("s2_hdr", 32'h01000000, 4'b1000);
    check("s2_out_count", 64'(out_q.size()), 64'(2));
    check_out("s2_out0", 0, 32'h02030405, 4'b1111, 1'b0);
    check_out("s2_out1", 1, 32'h06070800, 4'b1110, 1'b1);

    // n=0 pass-through, one-cycle latency
    clear_logs();
    send_cmd(3'd0);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    check("s3_lat0", 64'({valid_out, data_out, last_out}), 64'({1'b1, 32'h01020304, 1'b0}));
    send_beat(32'h05060708, 4'b1111, 1'b0);
    check("s3_lat1", 64'({valid_out, data_out, last_out}), 64'({1'b1, 32'h05060708, 1'b0}));
    send_beat(32'h090A0B0C, 4'b1111, 1'b1);
    check("s3_lat2", 64'({valid_out, data_out, last_out}), 64'({1'b1, 32'h090A0B0C, 1'b1}));
    idle(3);
    check_hdr("s3_hdr", 32'h00000000, 4'b0000);
    check("s3_out_count", 64'(out_q.size()), 64'(3));
    check_out("s3_out2", 2, 32'h090A0B0C, 4'b1111, 1'b1);

    // n=4 header-only packet, then n=2 packet
    clear_logs();
    send_cmd(3'd4);
    send_beat(32'h11223344, 4'b1111, 1'b1);
    idle(3);
    check_hdr("s4_hdr", 32'h11223344, 4'b1111);
    check("s4_no_out", 64'(out_q.size()), 64'(0));
    clear_logs();
    send_cmd(3'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0000, 4'b1100, 1'b1);
    idle(3);
    check_hdr("s4b_hdr", 32'hAABB0000, 4'b1100);
    check("s4b_out_count", 64'(out_q.size()), 64'(1));
    check_out("s4b_out0", 0, 32'hCCDDEEFF, 4'b1111, 1'b1);

    // Oversized count clamps to a full-beat header
    clear_logs();
    send_cmd(3'd7);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    send_beat(32'h99AABBCC, 4'b1000, 1'b1);
    idle(3);
    check_hdr("clamp_hdr", 32'h55667788, 4'b1111);
    check("clamp_out_count", 64'(out_q.size()), 64'(1));
    check_out("clamp_out0", 0, 32'h99000000, 4'b1000, 1'b1);

    // n=3 with downstream back-pressure mid-packet
    clear_logs();
    send_cmd(3'd3);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h090A0B0C;
    keep_in   = 4'b1100;
    last_in   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("s5_hold", 64'({valid_out, data_out, keep_out, last_out, ready_in}),
            64'({1'b1, 32'h04050607, 4'b1111, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(32'h090A0B0C, 4'b1100, 1'b1);
    idle(4);
    check("s5_out_count", 64'(out_q.size()), 64'(2));
    check_out("s5_out0", 0, 32'h04050607, 4'b1111, 1'b0);
    check_out("s5_out1", 1, 32'h08090A00, 4'b1110, 1'b1);

    // Reset in the middle of a packet, then a fresh n=2 packet
    send_cmd(3'd3);
    send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
    send_beat(32'h12345678, 4'b1111, 1'b0);
    rst_n = 1'b0;
    #1;
    check("s6_rst_out", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
    check("s6_rst_hdr", 64'({hdr_valid, hdr_data, hdr_keep}), 64'(0));
    check("s6_rst_ready", 64'({ready_in, ready_remove}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    idle(1);
    send_cmd(3'd2);
    send_beat(32'hA1B2C3D4, 4'b1111, 1'b0);
    send_beat(32'hE5F60000, 4'b1100, 1'b1);
    idle(3);
    check_hdr("s6_hdr", 32'hA1B20000, 4'b1100);
    check("s6_out_count", 64'(out_q.size()), 64'(1));
    check_out("s6_out0", 0, 32'hC3D4E5F6, 4'b1111, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
